// File: rtl/alu_4_bit.sv
// Registered signed ALU: ADD / SUB / NOT A / reduction-OR B into an OUT_W result.
// One clock of latency; synchronous active-high reset clears the result.
module alu_4_bit #(
  parameter int IN_W  = 4,
  parameter int OUT_W = IN_W + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              Opcode,
  input  logic signed [IN_W-1:0]  A,
  input  logic signed [IN_W-1:0]  B,
  output logic signed [OUT_W-1:0] C
);

  localparam int EXT_W = OUT_W - IN_W;

  generate
    if (OUT_W != IN_W + 1) begin : g_bad_width
      $error("alu_4_bit: OUT_W must equal IN_W+1");
    end
  endgenerate

  logic signed [OUT_W-1:0] w_a_ext;
  logic signed [OUT_W-1:0] w_b_ext;
  logic signed [OUT_W-1:0] w_result;
  logic signed [OUT_W-1:0] r_c;

  // Widen before arithmetic so ADD/SUB can never overflow the result.
  assign w_a_ext = {{EXT_W{A[IN_W-1]}}, A};
  assign w_b_ext = {{EXT_W{B[IN_W-1]}}, B};

  always_comb begin
    w_result = '0;
    case (Opcode)
      2'b00:   w_result = w_a_ext + w_b_ext;
      2'b01:   w_result = w_a_ext - w_b_ext;
      2'b10:   w_result = ~w_a_ext;
      2'b11:   w_result = {{(OUT_W-1){1'b0}}, |B};
      default: w_result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_c <= '0;
    else       r_c <= w_result;
  end

  assign C = r_c;

endmodule

// File: tb/tb_alu_4_bit.sv
// Directed table plus randomized back-to-back traffic for alu_4_bit.
// Inputs change on the falling edge; C is sampled 1ns after the rising edge and again mid-cycle.
module tb_alu_4_bit;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        Opcode;
  logic signed [3:0] A;
  logic signed [3:0] B;
  logic signed [4:0] C;

  always #5 clk = ~clk;

  alu_4_bit #(.IN_W(4), .OUT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .Opcode(Opcode),
    .A     (A),
    .B     (B),
    .C     (C)
  );

  typedef struct {
    logic              rst;
    logic [1:0]        op;
    logic signed [3:0] a;
    logic signed [3:0] b;
    logic signed [4:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic signed [4:0] exp);
    n_vec++;
    if (C !== exp) begin
      n_bad++;
      $display("FAIL %s: C=%0d (%b) expected %0d (%b)", name, C, C, exp, exp);
    end
  endtask

  task automatic apply(input logic rst, input logic [1:0] op,
                       input logic signed [3:0] a, input logic signed [3:0] b);
    @(negedge clk);
    reset = rst; Opcode = op; A = a; B = b;
    @(posedge clk);
    #1;
  endtask

  // Integer reference, independent of the RTL's bit-level formulation.
  function automatic logic signed [4:0] ref_f(input logic r, input logic [1:0] op,
                                              input logic signed [3:0] a,
                                              input logic signed [3:0] b);
    int res;
    if (r) return 5'sd0;
    case (op)
      2'b00:   res = int'(a) + int'(b);
      2'b01:   res = int'(a) - int'(b);
      2'b10:   res = -int'(a) - 1;
      default: res = (b != 4'sd0) ? 1 : 0;
    endcase
    return res[4:0];
  endfunction

  initial begin
    // {rst, op, A, B, expected C}; negatives written as raw bit patterns
    vecs.push_back('{1'b0, 2'b00, 4'sd7,   4'sd7,   5'b01110}); // 7+7=14
    vecs.push_back('{1'b0, 2'b00, 4'b1000, 4'b1000, 5'b10000}); // -8+-8=-16
    vecs.push_back('{1'b0, 2'b00, 4'b1101, 4'sd2,   5'b11111}); // -3+2=-1
    vecs.push_back('{1'b0, 2'b01, 4'sd7,   4'b1000, 5'b01111}); // 7-(-8)=15
    vecs.push_back('{1'b0, 2'b01, 4'b1000, 4'sd7,   5'b10001}); // -8-7=-15
    vecs.push_back('{1'b0, 2'b01, 4'sd4,   4'sd4,   5'b00000}); // 4-4=0
    vecs.push_back('{1'b0, 2'b10, 4'sd5,   4'sd0,   5'b11010}); // ~5=-6
    vecs.push_back('{1'b0, 2'b10, 4'sd5,   4'b1111, 5'b11010}); // B ignored
    vecs.push_back('{1'b0, 2'b10, 4'b1000, 4'sd3,   5'b00111}); // ~-8=7
    vecs.push_back('{1'b0, 2'b10, 4'sd0,   4'b1000, 5'b11111}); // ~0=-1
    vecs.push_back('{1'b0, 2'b10, 4'sd3,   4'sd1,   5'b11100}); // ~3=-4
    vecs.push_back('{1'b0, 2'b11, 4'sd0,   4'sd0,   5'b00000}); // |0=0
    vecs.push_back('{1'b0, 2'b11, 4'sd7,   4'sd0,   5'b00000}); // A ignored
    vecs.push_back('{1'b0, 2'b11, 4'sd0,   4'b1000, 5'b00001}); // |1000=1
    vecs.push_back('{1'b0, 2'b11, 4'b1000, 4'b1111, 5'b00001}); // |1111=1
    vecs.push_back('{1'b0, 2'b11, 4'sd5,   4'sd1,   5'b00001}); // |0001=1
    vecs.push_back('{1'b1, 2'b01, 4'sd7,   4'b1000, 5'b00000}); // reset beats SUB
    vecs.push_back('{1'b0, 2'b01, 4'sd7,   4'b1000, 5'b01111}); // no dead cycle after reset

    reset = 1'b1; Opcode = 2'b00; A = 4'sd0; B = 4'sd0;

    // Reset priority, hold, and immediate load on release.
    apply(1'b1, 2'b00, 4'sd3, 4'sd4);
    check("reset_prio", 5'sd0);
    apply(1'b1, 2'b00, 4'sd3, 4'sd4);
    check("reset_hold", 5'sd0);
    apply(1'b0, 2'b00, 4'sd3, 4'sd4);
    check("reset_release", 5'sd7);

    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].op, vecs[i].a, vecs[i].b);
      check($sformatf("vec[%0d]", i), vecs[i].exp);
    end

    // Back-to-back random traffic: one-cycle latency and mid-cycle stability.
    for (int k = 0; k < 200; k++) begin
      logic              r;
      logic [1:0]        op;
      logic signed [3:0] a;
      logic signed [3:0] b;
      logic signed [4:0] e;
      r  = ($urandom_range(3) == 0);
      op = 2'($urandom_range(3));
      a  = 4'($urandom_range(15));
      b  = 4'($urandom_range(15));
      e  = ref_f(r, op, a, b);
      apply(r, op, a, b);
      check($sformatf("rand[%0d] r=%0d op=%0d a=%0d b=%0d", k, r, op, a, b), e);
      #3;
      check($sformatf("rand_stable[%0d]", k), e);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
